// File: rtl/sr_ff_check_sequencer_pkg.sv
// Shared types for the SR flip-flop check sequencer: command opcodes, FSM states and S/R decode.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'b00,
    OP_RESET   = 2'b01,
    OP_SET     = 2'b10,
    OP_ILLEGAL = 2'b11
  } sr_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_APPLY  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Returns {S,R}; anything that is not a clean set/reset drives neither line.
  function automatic logic [1:0] decode_sr(input sr_op_t op);
    case (op)
      OP_SET:   return 2'b10;
      OP_RESET: return 2'b01;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/sr_ff_check_sequencer_cmd_buffer.sv
// Command register file for the sequencer: append-only writes, synchronous clear, async read by step index.
module sr_cmd_buffer import sr_seq_pkg::*; #(
  parameter  int SEQ_LEN = 8,
  localparam int IDX_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int CNT_W   = $clog2(SEQ_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  sr_op_t           wr_op,
  input  logic [IDX_W-1:0] rd_idx,
  output sr_op_t           rd_op,
  output logic [CNT_W-1:0] count
);

  // Storage is padded to a power of two so every rd_idx value addresses a real entry.
  localparam int DEPTH = 1 << IDX_W;

  sr_op_t           mem_q [DEPTH];
  sr_op_t           mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wr_en && (count_q < CNT_W'(SEQ_LEN))) begin
      mem_d[count_q[IDX_W-1:0]] = (wr_op == OP_ILLEGAL) ? OP_HOLD : wr_op;
      count_d                   = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= OP_HOLD;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign rd_op = mem_q[rd_idx];
  assign count = count_q;

endmodule

// File: rtl/sr_ff_check_sequencer.sv
// Sequencer that replays buffered SR commands into three SR flop implementations and checks them
// against a golden model. Define SR_SEQ_STOP_ON_MISMATCH_EN to end a run at the first failing check.
module sr_ff_check_sequencer import sr_seq_pkg::*; #(
  parameter  int SEQ_LEN       = 8,
  parameter  int SETTLE_CYCLES = 0,
  localparam int IDX_W         = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int CNT_W         = $clog2(SEQ_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             dut_rst,
  output logic             S,
  output logic             R,
  input  logic             q_jk,
  input  logic             q_d,
  input  logic             q_t,
  output logic             mismatch,
  output logic             illegal,
  output logic [7:0]       err_count,
  output logic [IDX_W-1:0] step_idx
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] step_idx_q, step_idx_d;
  logic [3:0]       settle_q, settle_d;
  logic             q_exp_q, q_exp_d;
  logic [7:0]       err_q, err_d;
  logic             mismatch_q, mismatch_d;
  logic             illegal_q, illegal_d;
  logic             ill_buf_q, ill_buf_d;
  logic             s_q, s_d, r_q, r_d;

  logic             push_s;
  logic [CNT_W-1:0] count_s;
  sr_op_t           rd_op_s;
  logic             any_diff_s;
  logic             last_step_s;
  logic [CNT_W:0]   next_idx_s;

  assign cmd_ready   = (state_q == ST_IDLE) && !start && (count_s < CNT_W'(SEQ_LEN));
  assign push_s      = cmd_valid && cmd_ready;
  assign any_diff_s  = (q_jk != q_exp_q) || (q_d != q_exp_q) || (q_t != q_exp_q);
  assign next_idx_s  = (CNT_W+1)'(step_idx_q) + (CNT_W+1)'(1);
  assign last_step_s = (next_idx_s >= {1'b0, count_s});

  sr_cmd_buffer #(.SEQ_LEN(SEQ_LEN)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_DONE),
    .wr_en  (push_s),
    .wr_op  (sr_op_t'(cmd_op)),
    .rd_idx (step_idx_d),
    .rd_op  (rd_op_s),
    .count  (count_s)
  );

  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    settle_d   = settle_q;
    q_exp_d    = q_exp_q;
    err_d      = err_q;
    mismatch_d = mismatch_q;
    illegal_d  = illegal_q;
    ill_buf_d  = ill_buf_q;

    // ill_buf remembers an illegal op in the pending buffer so INIT can re-arm illegal for this run.
    if (push_s && (cmd_op == OP_ILLEGAL)) begin
      illegal_d = 1'b1;
      ill_buf_d = 1'b1;
    end else begin
      ill_buf_d = ill_buf_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_INIT;
          step_idx_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        q_exp_d    = 1'b0;
        err_d      = 8'd0;
        mismatch_d = 1'b0;
        illegal_d  = ill_buf_q;
        state_d    = (count_s != '0) ? ST_APPLY : ST_DONE;
      end
      ST_APPLY: begin
        q_exp_d  = s_q ? 1'b1 : (r_q ? 1'b0 : q_exp_q);
        settle_d = 4'd0;
        state_d  = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
      end
      ST_SETTLE: begin
        if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (any_diff_s) begin
          mismatch_d = 1'b1;
          err_d      = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);
        end else begin
          mismatch_d = mismatch_q;
        end
`ifdef SR_SEQ_STOP_ON_MISMATCH_EN
        if (any_diff_s || last_step_s) begin
`else
        if (last_step_s) begin
`endif
          state_d = ST_DONE;
        end else begin
          state_d    = ST_APPLY;
          step_idx_d = step_idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        ill_buf_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // S/R are computed from the next state so the flop outputs line up with the APPLY cycle.
    {s_d, r_d} = (state_d == ST_APPLY) ? decode_sr(rd_op_s) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_idx_q <= '0;
      settle_q   <= 4'd0;
      q_exp_q    <= 1'b0;
      err_q      <= 8'd0;
      mismatch_q <= 1'b0;
      illegal_q  <= 1'b0;
      ill_buf_q  <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      settle_q   <= settle_d;
      q_exp_q    <= q_exp_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      illegal_q  <= illegal_d;
      ill_buf_q  <= ill_buf_d;
      s_q        <= s_d;
      r_q        <= r_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dut_rst   = (state_q == ST_INIT);
  assign S         = s_q;
  assign R         = r_q;
  assign mismatch  = mismatch_q;
  assign illegal   = illegal_q;
  assign err_count = err_q;
  assign step_idx  = step_idx_q;

endmodule

// File: tb/tb_sr_ff_check_sequencer.sv
// Randomized bench for sr_ff_check_sequencer: behavioural SR flops with injectable faults and a
// per-run reference built from the command list as an expected cycle trace.
module tb_sr_ff_check_sequencer;

  localparam int SEQ_LEN       = 8;
  localparam int SETTLE_CYCLES = 0;
  localparam int IDX_W         = 3;
`ifdef SR_SEQ_STOP_ON_MISMATCH_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, cmd_valid, start;
  logic [1:0] cmd_op;
  logic cmd_ready, busy, done, dut_rst, S, R, mismatch, illegal;
  logic q_jk, q_d, q_t;
  logic [7:0] err_count;
  logic [IDX_W-1:0] step_idx;

  always #5 clk = ~clk;

  sr_ff_check_sequencer #(.SEQ_LEN(SEQ_LEN), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .start(start), .busy(busy), .done(done), .dut_rst(dut_rst), .S(S), .R(R),
    .q_jk(q_jk), .q_d(q_d), .q_t(q_t), .mismatch(mismatch), .illegal(illegal),
    .err_count(err_count), .step_idx(step_idx)
  );

  // Ideal SR flop; fault selects a corruption of one of the three reported outputs.
  logic sr_q = 1'b0;
  int   fault = 0;
  always @(posedge clk) begin
    if (dut_rst)  sr_q <= 1'b0;
    else if (S)   sr_q <= 1'b1;
    else if (R)   sr_q <= 1'b0;
    else          sr_q <= sr_q;
  end
  assign q_jk = (fault == 3) ? ~sr_q : sr_q;
  assign q_d  = (fault == 1) ? 1'b1  : sr_q;
  assign q_t  = (fault == 2) ? 1'b0  : sr_q;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  int   mq[$];
  int   ops[$];
  bit   m_ill_buf = 1'b0, m_illegal = 1'b0, m_mis = 1'b0;
  int   m_err = 0, m_step = 0;
  logic [4:0] tr_vec[$];
  int   tr_idx[$];

  task automatic push_op(input int op);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    #1;
    chk_eq("cmd_ready", 32'(cmd_ready), 32'(mq.size() < SEQ_LEN));
    if (mq.size() < SEQ_LEN) begin
      mq.push_back((op == 3) ? 0 : op);
      if (op == 3) begin
        m_ill_buf = 1'b1;
        m_illegal = 1'b1;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Expected per-cycle {busy,done,dut_rst,S,R} from start sample to the done pulse.
  task automatic build_trace();
    bit g = 1'b0;
    int e = 0;
    tr_vec.delete();
    tr_idx.delete();
    tr_vec.push_back(5'b10100); tr_idx.push_back(-1);
    m_step = 0;
    for (int k = 0; k < mq.size(); k++) begin
      bit fail;
      logic [1:0] sr;
      sr = (mq[k] == 2) ? 2'b10 : (mq[k] == 1) ? 2'b01 : 2'b00;
      tr_vec.push_back({3'b100, sr}); tr_idx.push_back(k);
      for (int s = 0; s < SETTLE_CYCLES; s++) begin
        tr_vec.push_back(5'b10000); tr_idx.push_back(k);
      end
      tr_vec.push_back(5'b10000); tr_idx.push_back(k);
      if (mq[k] == 2) g = 1'b1;
      else if (mq[k] == 1) g = 1'b0;
      fail = (fault == 3) || (fault == 1 && !g) || (fault == 2 && g);
      if (fail) e++;
      m_step = k;
      if (fail && STOP) break;
    end
    tr_vec.push_back(5'b11000); tr_idx.push_back(-1);
    m_err = (e > 255) ? 255 : e;
    m_mis = (e > 0);
  endtask

  task automatic run_one(input int flt, input bit rej, input int abort_at);
    fault = flt;
    foreach (ops[i]) push_op(ops[i]);
    @(negedge clk);
    chk_eq("illegal_pre", 32'(illegal), 32'(m_illegal));
    start     = 1'b1;
    cmd_valid = rej;
    cmd_op    = 2'b10;
    #1;
    if (rej) chk_eq("ready_vs_start", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    start     = 1'b0;
    cmd_valid = 1'b0;
    m_illegal = m_ill_buf;
    build_trace();
    for (int i = 0; i < tr_vec.size(); i++) begin
      @(negedge clk);
      chk_eq("ctl_trace", 32'({busy, done, dut_rst, S, R}), 32'(tr_vec[i]));
      if (tr_idx[i] >= 0) chk_eq("step_idx_run", 32'(step_idx), 32'(tr_idx[i]));
      if (i == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("abort_ctl", 32'({busy, done, dut_rst, S, R}), 32'd0);
        chk_eq("abort_ready", 32'(cmd_ready), 32'd1);
        chk_eq("abort_stat", 32'({mismatch, illegal, err_count, step_idx}), 32'd0);
        mq.delete();
        m_ill_buf = 1'b0; m_illegal = 1'b0;
        return;
      end
    end
    mq.delete();
    m_ill_buf = 1'b0;
    @(negedge clk);
    chk_eq("idle_ctl", 32'({busy, done, dut_rst, S, R}), 32'd0);
    chk_eq("err_count", 32'(err_count), 32'(m_err));
    chk_eq("mismatch", 32'(mismatch), 32'(m_mis));
    chk_eq("illegal", 32'(illegal), 32'(m_illegal));
    chk_eq("step_idx_final", 32'(step_idx), 32'(m_step));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_ctl", 32'({busy, done, dut_rst, S, R}), 32'd0);
    chk_eq("rst_ready", 32'(cmd_ready), 32'd1);
    chk_eq("rst_stat", 32'({mismatch, illegal, err_count, step_idx}), 32'd0);

    ops = '{2, 0, 1, 0};                           run_one(0, 1'b0, -1);
    ops = '{1, 1};                                 run_one(1, 1'b0, -1);
    ops.delete();
    for (int i = 0; i < 9; i++) ops.push_back($urandom_range(0, 3));
    run_one(0, 1'b0, -1);
    ops = '{2, 3};                                 run_one(0, 1'b0, -1);
    ops = '{3};                                    run_one(2, 1'b0, -1);
    ops.delete();                                  run_one(0, 1'b1, -1);
    ops = '{2, 1, 2, 0};
    run_one(0, 1'b0, 1 + 2 * (2 + SETTLE_CYCLES) + 1 + SETTLE_CYCLES);
    ops = '{1, 2};                                 run_one(2, 1'b1, -1);

    for (int r = 0; r < 40; r++) begin
      ops.delete();
      for (int i = 0; i < int'($urandom_range(0, 10)); i++) ops.push_back($urandom_range(0, 3));
      run_one($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
